ascon_sbox_layer_seq: RTL
=========================

ASCON_SBOX_LAYER_SEQ -- requirements
Module: ascon_sbox_layer_seq

Interface
REQ-001 The block SHALL have parameter LANES_PER_CYCLE, default 16, giving the S-box lanes looked up per cycle; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL define NUM_CHUNKS = 64/LANES_PER_CYCLE as a derived constant.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port state_i, input, [4:0][63:0]: Ascon state words x0..x4.
REQ-006 The block SHALL have port in_valid_i, input, 1 bit: state_i is valid.
REQ-007 The block SHALL have port in_ready_o, output, 1 bit: block accepts state_i.
REQ-008 The block SHALL have port state_o, output, [4:0][63:0]: substituted state words x0..x4.
REQ-009 The block SHALL have port out_valid_o, output, 1 bit: state_o is valid.
REQ-010 The block SHALL have port out_ready_i, input, 1 bit: downstream accepts state_o.
REQ-011 The block SHALL have port sbox_addr_o, output, [63:0][4:0]: per-lane address to the S-box LUT.
REQ-012 The block SHALL have port sbox_data_i, input, [63:0][4:0]: per-lane LUT result, combinational from sbox_addr_o in the same cycle.
REQ-013 The block SHALL have port busy_o, output, 1 bit: a lookup is in progress (state LOOKUP).

Function
REQ-014 The block SHALL implement FSM states IDLE, LOOKUP and DONE, plus a chunk counter of width clog2(NUM_CHUNKS), minimum 1 bit.
REQ-015 In IDLE the block SHALL drive in_ready_o=1; on in_valid_i=1 it SHALL capture state_i into the input register, clear the counter and go to LOOKUP.
REQ-016 Lane packing SHALL be: lane i address = {x0[i], x1[i], x2[i], x3[i], x4[i]}, with x0 as the MSB.
REQ-017 In LOOKUP with counter c, lanes c*LANES_PER_CYCLE through c*LANES_PER_CYCLE+LANES_PER_CYCLE-1 SHALL carry packed addresses, and all other lanes SHALL be driven 0.
REQ-018 Each LOOKUP cycle SHALL write sbox_data_i for the active lanes only into the result register, unpacked with bit4 to x0[i] and bit0 to x4[i]; inactive lanes SHALL hold their value.
REQ-019 The counter SHALL increment each LOOKUP cycle; at c = NUM_CHUNKS-1 the FSM SHALL go to DONE and the counter SHALL wrap to 0.
REQ-020 Latency: out_valid_o SHALL rise exactly NUM_CHUNKS rising edges after the accepting edge (1 for LANES_PER_CYCLE=64, 4 for 16).
REQ-021 In DONE the block SHALL drive out_valid_o=1; on out_ready_i=1 it SHALL go to IDLE.
REQ-022 state_o SHALL always equal the result register, and SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-023 in_ready_o SHALL be 0 in LOOKUP and DONE; there SHALL be no overlap of operations and no same-cycle DONE to accept path.
REQ-024 in_valid_i SHALL be ignored outside IDLE, and state_i changes after acceptance SHALL not affect the result.
REQ-025 In IDLE and DONE, sbox_addr_o SHALL be all zero.
REQ-026 All outputs SHALL be decoded from registers only, with no combinational path from in_valid_i or out_ready_i to any output.

Reset
REQ-027 With rst_i=1 at a rising edge, the block SHALL set the FSM to IDLE, the counter, input register and result register to 0, taking priority over any handshake.
REQ-028 After the reset edge: in_ready_o=1, out_valid_o=0, busy_o=0, state_o=0, sbox_addr_o=0.
REQ-029 A reset during LOOKUP or DONE SHALL discard the operation, with no out_valid_o pulse afterward.

Verification
REQ-030 L=64, standard Ascon LUT, state_i all zero -> after 1 edge out_valid_o=1; x2=all ones, x0/x1/x3/x4=0 (sbox(0)=0x04).
REQ-031 L=16, state_i all ones -> out_valid_o rises 4 edges after accept; x0, x2, x3, x4 all ones and x1=0 (sbox(0x1F)=0x17); busy_o=1 for exactly 4 cycles.
REQ-032 L=8, identity LUT, random state_i -> state_o equals state_i; per-cycle check that only the 8 active lanes of sbox_addr_o are nonzero-capable, counter 0..7.
REQ-033 Backpressure: out_ready_i=0 for 5 cycles in DONE -> state_o stable, in_ready_o=0, and in_valid_i pulses are ignored; output is accepted on the 6th cycle, then IDLE.
REQ-034 Assert rst_i at the second LOOKUP cycle (L=16) -> next cycle IDLE, state_o=0, out_valid_o never asserted; a subsequent operation completes correctly.

Source files
------------

// File: rtl/ascon_sbox_layer_seq_if.sv
// Handshake and S-box LUT bus for the sequential Ascon substitution layer.
// The slave side is the layer itself; the master side is its environment.
interface ascon_sbox_layer_seq_if;
    logic [4:0][63:0] state_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [4:0][63:0] state_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [63:0][4:0] sbox_addr_o;
    logic [63:0][4:0] sbox_data_i;
    logic             busy_o;

    modport slave (
        input  state_i,
        input  in_valid_i,
        output in_ready_o,
        output state_o,
        output out_valid_o,
        input  out_ready_i,
        output sbox_addr_o,
        input  sbox_data_i,
        output busy_o
    );

    modport master (
        output state_i,
        output in_valid_i,
        input  in_ready_o,
        input  state_o,
        input  out_valid_o,
        output out_ready_i,
        input  sbox_addr_o,
        output sbox_data_i,
        input  busy_o
    );
endinterface

// File: rtl/ascon_sbox_layer_seq.sv
// Ascon 5-bit S-box layer over 64 lanes, looked up LANES_PER_CYCLE lanes at a time
// through an external combinational LUT.
//
// state  | meaning
// IDLE   | ready for a new state, LUT address bus held at zero
// LOOKUP | driving one chunk of packed lane addresses per cycle
// DONE   | result held on state_o until downstream takes it
module ascon_sbox_layer_seq #(
    parameter int LANES_PER_CYCLE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ascon_sbox_layer_seq_if.slave bus
);
    localparam int NUM_CHUNKS = 64 / LANES_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] chunk_q;
    logic [4:0][63:0] in_q;
    logic [4:0][63:0] res_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [63:0]      lane_active;
    logic [63:0][4:0] addr;

    // A lane is active when it belongs to the chunk selected by the counter.
    always_comb begin
        lane_active = '0;
        for (int i = 0; i < 64; i++) begin
            lane_active[i] = (state_q == LOOKUP) &&
                             (CNT_W'(i / LANES_PER_CYCLE) == chunk_q);
        end
    end

    always_comb begin
        addr = '0;
        for (int i = 0; i < 64; i++) begin
            if (lane_active[i]) begin
                addr[i] = {in_q[0][i], in_q[1][i], in_q[2][i], in_q[3][i], in_q[4][i]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            chunk_q     <= '0;
            in_q        <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (lane_active[i]) begin
                    res_q[0][i] <= bus.sbox_data_i[i][4];
                    res_q[1][i] <= bus.sbox_data_i[i][3];
                    res_q[2][i] <= bus.sbox_data_i[i][2];
                    res_q[3][i] <= bus.sbox_data_i[i][1];
                    res_q[4][i] <= bus.sbox_data_i[i][0];
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        in_q       <= bus.state_i;
                        chunk_q    <= '0;
                        state_q    <= LOOKUP;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (chunk_q == LAST_CHUNK) begin
                        chunk_q     <= '0;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        chunk_q <= chunk_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Return to IDLE only; a new state is taken no earlier than next cycle.
                    if (bus.out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    chunk_q     <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.state_o     = res_q;
    assign bus.sbox_addr_o = addr;
endmodule
